// File: rtl/buffer_write_arbiter.sv
// Round-robin, burst-granular write-port arbiter for the credit-based CDC buffer.
// Optional per-requester accepted-beat counters: define BUFFER_WRITE_ARBITER_STATS_EN.
module buffer_write_arbiter #(
   parameter int N_REQ      = 4,
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 1024,
   parameter int CREDIT_W   = $clog2(DEPTH) + 1,
   parameter int MAX_BURST  = 16,
   parameter int MIN_CREDIT = 1
) (
   input  logic                   re_clk,
   input  logic                   re_reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_last,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [CREDIT_W-1:0]    buf_credit,
   output logic                   buf_valid,
   output logic [WIDTH-1:0]       buf_data,
   output logic [N_REQ-1:0]       grant,
   output logic                   busy
`ifdef BUFFER_WRITE_ARBITER_STATS_EN
   ,
   output logic [N_REQ*16-1:0]    beat_total
`endif
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] rr_last;
   logic [IDX_W-1:0] winner;
   logic [CNT_W-1:0] beat_cnt;
   logic             fire;
   logic             last_beat;
   logic             start_grant;

   // Rotating priority search starting just after the previous owner; the
   // modulo keeps a non-power-of-two N_REQ from selecting a phantom index.
   always_comb begin
      int   idx;
      logic found;
      // NOTE: every combinational output gets a default first so no latch is inferred.
      winner = rr_last;
      found  = 1'b0;
      idx    = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = (int'(rr_last) + off) % N_REQ;
         if (!found && req_valid[idx]) begin
            winner = IDX_W'(idx);
            found  = 1'b1;
         end
      end
   end

   assign start_grant = (|req_valid) && (buf_credit >= CREDIT_W'(MIN_CREDIT));

   // A beat moves only when the owner offers one and the buffer has room.
   assign fire      = (state == ST_BURST) && !re_reset && req_valid[owner] && (buf_credit != '0);
   assign last_beat = req_last[owner] || (beat_cnt == CNT_W'(MAX_BURST - 1));
   assign buf_valid = fire;
   assign req_ready = fire ? (N_REQ'(1) << owner) : '0;
   assign buf_data  = req_data[int'(owner)*WIDTH +: WIDTH];

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge re_clk) begin
      if (re_reset) begin
         state    <= ST_IDLE;
         owner    <= '0;
         grant    <= '0;
         beat_cnt <= '0;
         rr_last  <= IDX_W'(N_REQ - 1);
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_grant) begin
                  state    <= ST_BURST;
                  owner    <= winner;
                  grant    <= N_REQ'(1) << winner;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            ST_BURST: begin
               if (fire) begin
                  if (last_beat) begin
                     state    <= ST_IDLE;
                     grant    <= '0;
                     rr_last  <= owner;
                     beat_cnt <= '0;
                     busy     <= 1'b0;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BUFFER_WRITE_ARBITER_STATS_EN
   logic [15:0] beat_cnt_q [N_REQ];

   // NOTE: the counter array is small register state, so it is cleared by reset like any flop.
   always_ff @(posedge re_clk) begin
      if (re_reset) begin
         for (int i = 0; i < N_REQ; i++) beat_cnt_q[i] <= '0;
      end else if (fire && (beat_cnt_q[owner] != 16'hFFFF)) begin
         beat_cnt_q[owner] <= beat_cnt_q[owner] + 16'd1;
      end
   end

   always_comb begin
      beat_total = '0;
      for (int i = 0; i < N_REQ; i++) beat_total[i*16 +: 16] = beat_cnt_q[i];
   end
`endif

endmodule
